odd_parity_serial_tx: RTL and testbench
=======================================

Name: odd_parity_serial_tx

Overview:
Sequencing controller around the team's odd-parity generator. Accepts N-bit words over a valid/ready handshake, computes the odd-parity bit, and shifts the word out serially LSB-first followed by the parity bit, each bit held for a programmable number of clocks. Sits between a parallel producer and a single-wire serial link; frame pacing and accounting live here.

Parameters:
N, 4, data word width in bits (>=1)
CLKS_PER_BIT, 2, clocks each serial bit is held on tx_out (>=1)
GAP_CYCLES, 1, idle clocks inserted after each frame before in_ready re-asserts (>=0)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  producer has a word on in_data
in_data  input  N  word to transmit
in_ready  output  1  controller can accept a word this cycle
tx_out  output  1  serial line; 1 when idle
tx_valid  output  1  tx_out carries a data or parity bit
tx_last  output  1  tx_out carries the parity bit
busy  output  1  frame in progress (DATA, PARITY or GAP)
frame_done  output  1  one-cycle pulse on final clock of parity bit
frame_count  output  16  number of completed frames, wraps

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst high at rising edge): state IDLE, in_ready=1, tx_out=1, tx_valid=0, tx_last=0, busy=0, frame_done=0, frame_count=0, internal regs cleared.
- States: IDLE, DATA, PARITY, GAP.
- IDLE: in_ready=1, tx_out=1. On edge with in_valid&&in_ready: latch in_data into shift reg, latch parity = ~^in_data, bit counter=0, clock counter=0, go DATA. Accept cycle is cycle t.
- DATA (cycles t+1 .. t+N*CLKS_PER_BIT): tx_valid=1, tx_out=shift_reg[0], busy=1, in_ready=0. Clock counter counts 0..CLKS_PER_BIT-1; at terminal count shift right, bit counter++; after bit N-1 terminal count go PARITY.
- PARITY (next CLKS_PER_BIT cycles): tx_out=latched parity, tx_valid=1, tx_last=1. On final cycle frame_done=1 and frame_count increments at that edge. Then GAP if GAP_CYCLES>0 else IDLE.
- GAP: tx_out=1, tx_valid=0, busy=1, in_ready=0 for exactly GAP_CYCLES cycles, then IDLE.
- Frame period (accept to next possible accept) = 1 + (N+1)*CLKS_PER_BIT + GAP_CYCLES cycles.
- Parity rule: total count of 1s across N data bits plus parity bit is always odd; in_data=0 gives parity 1.
- in_data/in_valid changes after accept are ignored until return to IDLE; in_valid while not ready is not consumed (producer holds).
- frame_count wraps 16'hFFFF -> 0 without error.
- rst mid-frame: frame aborted immediately, all outputs to reset values, no frame_done, frame_count cleared.
- All outputs registered; no combinational path from in_valid to in_ready.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=1, tx_out=1, tx_valid=0, frame_count=0, no accept during reset.
- N=4,CPB=2,GAP=1: accept 4'b1011 at cycle t -> tx_out 1,1,0,1 each 2 cycles on t+1..t+8, parity 0 on t+9..t+10 with tx_last=1, frame_done at t+10, GAP t+11, in_ready=1 at t+12.
- Word 4'b0000 -> data bits all 0, parity bit 1; word 4'b1111 -> parity 1; word 4'b0001 -> parity 0.
- Back-to-back: in_valid held high with 3 words -> accepts exactly 12 cycles apart, frame_count=3, in_data changes mid-frame not transmitted.
- Reset at t+5 mid-DATA -> next cycle tx_out=1, tx_valid=0, busy=0, no frame_done, frame_count=0; new word then transmits correctly.
- Sweep all 16 words for N=4, GAP_CYCLES=0, CPB=1 -> each frame 6 cycles, serial bits match word LSB-first, ones count across 5 bits odd for every word.

Source files
------------

// File: rtl/odd_parity_serial_tx.sv
// Serial transmitter: accepts an N-bit word, sends it LSB-first followed by an
// odd-parity bit, each bit held CLKS_PER_BIT clocks, then idles GAP_CYCLES clocks.
module odd_parity_serial_tx #(
  parameter int N            = 4,
  parameter int CLKS_PER_BIT = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         tx_out,
  output logic         tx_valid,
  output logic         tx_last,
  output logic         busy,
  output logic         frame_done,
  output logic [15:0]  frame_count,
  output logic [1:0]   state_dbg
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   shift_reg, shift_reg_n;
  logic           parity_bit, parity_bit_n;
  logic [BW-1:0]  bit_cnt, bit_cnt_n;
  logic [CW-1:0]  clk_cnt, clk_cnt_n;
  logic [GW-1:0]  gap_cnt, gap_cnt_n;
  logic [15:0]    frame_count_n;
  logic           in_ready_n, tx_out_n, tx_valid_n, tx_last_n, busy_n, frame_done_n;

  assign state_dbg = state;

  // Handshake: a word transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready is a flop, so it never depends on in_valid.
  always_comb begin
    state_n       = state;
    shift_reg_n   = shift_reg;
    parity_bit_n  = parity_bit;
    bit_cnt_n     = bit_cnt;
    clk_cnt_n     = clk_cnt;
    gap_cnt_n     = gap_cnt;
    frame_count_n = frame_count;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          shift_reg_n  = in_data;
          parity_bit_n = ~^in_data;
          bit_cnt_n    = '0;
          clk_cnt_n    = '0;
          state_n      = DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_n   = '0;
          shift_reg_n = shift_reg >> 1;
          if (bit_cnt == BW'(N - 1)) begin
            bit_cnt_n = '0;
            state_n   = PARITY;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      PARITY: begin
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_n     = '0;
          gap_cnt_n     = '0;
          frame_count_n = frame_count + 16'd1;
          state_n       = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next-state values so they can be registered
    // and still line up with the cycle the state occupies.
    in_ready_n   = (state_n == IDLE);
    busy_n       = (state_n != IDLE);
    tx_valid_n   = (state_n == DATA) || (state_n == PARITY);
    tx_last_n    = (state_n == PARITY);
    frame_done_n = (state_n == PARITY) && (clk_cnt_n == CW'(CLKS_PER_BIT - 1));
    tx_out_n     = 1'b1;
    if (state_n == DATA)   tx_out_n = shift_reg_n[0];
    if (state_n == PARITY) tx_out_n = parity_bit_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      bit_cnt     <= '0;
      clk_cnt     <= '0;
      gap_cnt     <= '0;
      frame_count <= 16'd0;
      in_ready    <= 1'b1;
      tx_out      <= 1'b1;
      tx_valid    <= 1'b0;
      tx_last     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      shift_reg   <= shift_reg_n;
      parity_bit  <= parity_bit_n;
      bit_cnt     <= bit_cnt_n;
      clk_cnt     <= clk_cnt_n;
      gap_cnt     <= gap_cnt_n;
      frame_count <= frame_count_n;
      in_ready    <= in_ready_n;
      tx_out      <= tx_out_n;
      tx_valid    <= tx_valid_n;
      tx_last     <= tx_last_n;
      busy        <= busy_n;
      frame_done  <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Directed bench: instance a uses N=4/CPB=2/GAP=1, instance b uses N=4/CPB=1/GAP=0
// for the full 16-word sweep.
module tb_odd_parity_serial_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid_b;
  logic [3:0]  in_data, in_data_b;
  logic        in_ready, tx_out, tx_valid, tx_last, busy, frame_done;
  logic        in_ready_b, tx_out_b, tx_valid_b, tx_last_b, busy_b, frame_done_b;
  logic [15:0] frame_count, frame_count_b;
  logic [1:0]  state_dbg, state_dbg_b;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  odd_parity_serial_tx #(.N(4), .CLKS_PER_BIT(2), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_out(tx_out), .tx_valid(tx_valid), .tx_last(tx_last),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .state_dbg(state_dbg)
  );

  odd_parity_serial_tx #(.N(4), .CLKS_PER_BIT(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .tx_out(tx_out_b), .tx_valid(tx_valid_b), .tx_last(tx_last_b),
    .busy(busy_b), .frame_done(frame_done_b), .frame_count(frame_count_b),
    .state_dbg(state_dbg_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on instance a, starting in a cycle where in_ready should be high.
  task automatic frame_a(input logic [3:0] word, input logic par, input string tag);
    logic exp_bit;
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = word;
    tick();
    in_valid = 1'b0;
    in_data  = ~word;
    for (int c = 0; c < 10; c++) begin
      exp_bit = (c < 8) ? word[c / 2] : par;
      check($sformatf("%s_out%0d", tag, c), tx_out, exp_bit);
      check($sformatf("%s_valid%0d", tag, c), tx_valid, 1);
      check($sformatf("%s_last%0d", tag, c), tx_last, (c >= 8));
      check($sformatf("%s_done%0d", tag, c), frame_done, (c == 9));
      check($sformatf("%s_busyrdy%0d", tag, c), {busy, in_ready}, 2'b10);
      tick();
    end
    check({tag, "_gap"}, {tx_out, tx_valid, busy, in_ready, frame_done}, 5'b10100);
    tick();
    check({tag, "_idle"}, {in_ready, busy, tx_out}, 3'b101);
  endtask

  initial begin
    logic [3:0]  words [3];
    logic        pars  [3];
    int          acc   [3];
    int          k, cyc, ones;
    bit          done;
    logic [15:0] par_tbl;

    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 4'b1011;
    in_valid_b = 1'b0;
    in_data_b  = 4'b0000;
    repeat (3) tick();
    check("rst_ready", in_ready, 1);
    check("rst_tx_out", tx_out, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_state", state_dbg, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("post_rst_idle", {busy, in_ready}, 2'b01);

    frame_a(4'b1011, 1'b0, "w1011");
    check("fc_after_1", frame_count, 1);
    frame_a(4'b0000, 1'b1, "w0000");
    frame_a(4'b1111, 1'b1, "w1111");
    frame_a(4'b0001, 1'b0, "w0001");
    check("fc_after_4", frame_count, 4);

    // Back-to-back with in_valid held high and junk data while busy.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("fc_cleared", frame_count, 0);
    words[0] = 4'b0101; pars[0] = 1'b1;
    words[1] = 4'b1110; pars[1] = 1'b0;
    words[2] = 4'b1000; pars[2] = 1'b0;
    k = 0; cyc = 0; done = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 80 && !done; i++) begin
      if (tx_valid) begin
        if (exp_q.size() == 0) check("b2b_extra_bit", 1, 0);
        else check("b2b_bit", tx_out, exp_q.pop_front());
      end
      if (in_ready && k < 3) begin
        in_valid = 1'b1;
        in_data  = words[k];
        acc[k]   = cyc;
        for (int b = 0; b < 4; b++) begin
          exp_q.push_back(words[k][b]);
          exp_q.push_back(words[k][b]);
        end
        exp_q.push_back(pars[k]);
        exp_q.push_back(pars[k]);
        k++;
      end else if (k < 3) begin
        in_data = 4'($urandom_range(0, 15));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
      if (k == 3 && frame_count == 16'd3 && exp_q.size() == 0) done = 1;
    end
    check("b2b_done", done, 1);
    check("b2b_space01", acc[1] - acc[0], 12);
    check("b2b_space12", acc[2] - acc[1], 12);
    check("b2b_fc", frame_count, 3);
    in_valid = 1'b0;
    repeat (2) tick();

    // Reset in the middle of DATA.
    check("mid_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 4'b1011;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("mid_in_data", {tx_valid, busy}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_line", {tx_out, tx_valid, tx_last, busy, frame_done}, 5'b10000);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_fc", frame_count, 0);
    frame_a(4'b0001, 1'b0, "post_mid");
    check("post_mid_fc", frame_count, 1);

    // Full sweep on instance b; bit w of par_tbl is the odd-parity bit of w.
    par_tbl = 16'h9669;
    for (int w = 0; w < 16; w++) begin
      check($sformatf("sw%0d_ready", w), in_ready_b, 1);
      in_valid_b = 1'b1;
      in_data_b  = 4'(w);
      tick();
      in_valid_b = 1'b0;
      ones = 0;
      for (int i = 0; i < 5; i++) begin
        check($sformatf("sw%0d_valid%0d", w, i), tx_valid_b, 1);
        check($sformatf("sw%0d_last%0d", w, i), tx_last_b, (i == 4));
        check($sformatf("sw%0d_done%0d", w, i), frame_done_b, (i == 4));
        if (i < 4) check($sformatf("sw%0d_bit%0d", w, i), tx_out_b, w[i]);
        else       check($sformatf("sw%0d_par", w), tx_out_b, par_tbl[w]);
        ones += int'(tx_out_b);
        tick();
      end
      check($sformatf("sw%0d_odd", w), ones % 2, 1);
    end
    check("sw_ready_end", in_ready_b, 1);
    check("sw_fc", frame_count_b, 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
